// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW distance engine: controller states,
// default geometry and the arithmetic helpers used by the matrix cell.
package dtw_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMPUTE,
      DONE
   } state_t;

   localparam int unsigned DTW_N  = 4;
   localparam int unsigned DTW_W  = 2;
   localparam int unsigned DTW_DW = 6;

   // Unsigned add clamped to maxv; the 33-bit sum keeps the carry visible.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] maxv);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, maxv}) return maxv;
      return s[31:0];
   endfunction

   function automatic logic [31:0] min3(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [31:0] z);
      logic [31:0] m;
      m = (x < y) ? x : y;
      return (m < z) ? m : z;
   endfunction

endpackage

// File: rtl/dtw_cell.sv
// One DTW accumulated-cost cell, purely combinational.
// Local cost is the squared difference by default; defining DTW_ABS_COST_EN
// switches it to the absolute difference.
module dtw_cell
   import dtw_pkg::*;
#(
   parameter int unsigned W  = DTW_W,
   parameter int unsigned DW = DTW_DW
) (
   input  logic [W-1:0]  a_elem,
   input  logic [W-1:0]  b_elem,
   input  logic [DW-1:0] up,
   input  logic [DW-1:0] left,
   input  logic [DW-1:0] diag,
   input  logic          first_row,
   input  logic          first_col,
   output logic [DW-1:0] d
);

   localparam logic [31:0] MAXV = 32'((64'd1 << DW) - 64'd1);

   logic [W-1:0]   diff;
   logic [2*W-1:0] cost;
   logic [DW-1:0]  prev;

   // Local cost, predecessor selection and saturating accumulation
   always_comb begin
      diff = (a_elem > b_elem) ? (a_elem - b_elem) : (b_elem - a_elem);
`ifdef DTW_ABS_COST_EN
      cost = (2*W)'(diff);
`else
      cost = (2*W)'(diff) * (2*W)'(diff);
`endif
      if (first_row && first_col)
         prev = '0;
      else if (first_row)
         prev = left;
      else if (first_col)
         prev = up;
      else
         prev = DW'(min3(32'(up), 32'(left), 32'(diag)));
      d = DW'(sat_add(32'(cost), 32'(prev), MAXV));
   end

endmodule

// File: rtl/dtw_module.sv
// DTW distance engine: serially loads a reference and a test sequence
// (element 0 first, MSB first), fills the accumulated-cost matrix one cell
// per clock and holds the final distance with a level valid flag.
// Optional macro: DTW_ABS_COST_EN (absolute-difference local cost).
module dtw_module
   import dtw_pkg::*;
#(
   parameter int unsigned N  = DTW_N,
   parameter int unsigned W  = DTW_W,
   parameter int unsigned DW = DTW_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          InSample,
   input  logic          InTest,
   input  logic          Start,
   output logic          valid,
   output logic [DW-1:0] Out_Euclidean_Distatnce
);

   localparam int unsigned LB = N * W;
   localparam int unsigned CW = $clog2(LB + 1);
   localparam int unsigned IW = $clog2(N + 1);

   state_t        state;
   logic [LB-1:0] a_sr;
   logic [LB-1:0] b_sr;
   logic [CW-1:0] bit_cnt;
   logic [IW-1:0] i_cnt;
   logic [IW-1:0] j_cnt;
   logic [DW-1:0] row [N];
   logic [DW-1:0] diag_q;

   logic [W-1:0]  a_elem;
   logic [W-1:0]  b_elem;
   logic [DW-1:0] up;
   logic [DW-1:0] left;
   logic [DW-1:0] d_cell;

   // Select the operands of the current cell from the shift registers and row buffer
   always_comb begin
      a_elem = '0;
      b_elem = '0;
      up     = '0;
      left   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (i_cnt == IW'(k)) a_elem = a_sr[(N-1-k)*W +: W];
         if (j_cnt == IW'(k)) begin
            b_elem = b_sr[(N-1-k)*W +: W];
            up     = row[k];
         end
         if (k < N - 1 && j_cnt == IW'(k + 1)) left = row[k];
      end
   end

   dtw_cell #(
      .W  (W),
      .DW (DW)
   ) u_cell (
      .a_elem    (a_elem),
      .b_elem    (b_elem),
      .up        (up),
      .left      (left),
      .diag      (diag_q),
      .first_row (i_cnt == '0),
      .first_col (j_cnt == '0),
      .d         (d_cell)
   );

   // Controller: load, one cell per clock, then a final edge publishes the result.
   // A single row buffer is used: row[j] holds D(i-1,j) until overwritten, row[j-1]
   // already holds D(i,j-1), and diag_q keeps the old row[j-1] as D(i-1,j-1).
   always_ff @(posedge clk) begin
      if (rst) begin
         state                   <= IDLE;
         valid                   <= 1'b0;
         Out_Euclidean_Distatnce <= '0;
         a_sr                    <= '0;
         b_sr                    <= '0;
         bit_cnt                 <= '0;
         i_cnt                   <= '0;
         j_cnt                   <= '0;
         diag_q                  <= '0;
         for (int unsigned k = 0; k < N; k++) row[k] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state   <= LOAD;
                  valid   <= 1'b0;
                  bit_cnt <= '0;
               end
            end
            LOAD: begin
               a_sr    <= {a_sr[LB-2:0], InSample};
               b_sr    <= {b_sr[LB-2:0], InTest};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == CW'(LB - 1)) begin
                  state <= COMPUTE;
                  i_cnt <= '0;
                  j_cnt <= '0;
               end
            end
            COMPUTE: begin
               if (i_cnt == IW'(N)) begin
                  Out_Euclidean_Distatnce <= row[N-1];
                  valid                   <= 1'b1;
                  state                   <= DONE;
               end else begin
                  for (int unsigned k = 0; k < N; k++)
                     if (j_cnt == IW'(k)) row[k] <= d_cell;
                  diag_q <= up;
                  if (j_cnt == IW'(N - 1)) begin
                     j_cnt <= '0;
                     i_cnt <= i_cnt + 1'b1;
                  end else begin
                     j_cnt <= j_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dtw_module.sv
// Directed, table-driven bench for dtw_module (N=4, W=2, DW=6).
// Expected distances are hand-computed for both cost modes (DTW_ABS_COST_EN).
module tb_dtw_module;

   localparam int unsigned DW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          InSample;
   logic          InTest;
   logic          Start;
   logic          valid;
   logic [DW-1:0] Out_Euclidean_Distatnce;

   int n_vec = 0;
   int n_err = 0;

   dtw_module #(
      .N  (4),
      .W  (2),
      .DW (DW)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .InSample                (InSample),
      .InTest                  (InTest),
      .Start                   (Start),
      .valid                   (valid),
      .Out_Euclidean_Distatnce (Out_Euclidean_Distatnce)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]    s;      // sample bits, element 0 MSB first from bit 7
      logic [7:0]    t;      // test bits
      int            pulse;  // edge index for a stray Start pulse, 0 = none
      logic [DW-1:0] exp;
      string         name;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Full transaction: Start edge (edge 0), 8 load edges, then edges 9..25.
   task automatic run(input vec_t v, input logic [DW-1:0] old_out);
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Start = 1'b0;
      chk({v.name, " valid drop on accept"}, 32'(valid), 32'd0);
      chk({v.name, " old out held"}, 32'(Out_Euclidean_Distatnce), 32'(old_out));
      for (int k = 0; k < 8; k++) begin
         InSample = v.s[7-k];
         InTest   = v.t[7-k];
         Start    = (v.pulse == k + 1);
         @(posedge clk);
         @(negedge clk);
         Start = 1'b0;
      end
      for (int e = 9; e <= 25; e++) begin
         InSample = 1'b1;   // garbage outside LOAD must be ignored
         InTest   = ~InTest;
         Start    = (v.pulse == e);
         @(posedge clk);
         @(negedge clk);
         Start = 1'b0;
         if (e == 24) chk({v.name, " valid low at edge 24"}, 32'(valid), 32'd0);
      end
      chk({v.name, " valid at edge 25"}, 32'(valid), 32'd1);
      chk({v.name, " distance"}, 32'(Out_Euclidean_Distatnce), 32'(v.exp));
      repeat (4) @(negedge clk);
      chk({v.name, " valid held"}, 32'(valid), 32'd1);
      chk({v.name, " distance held"}, 32'(Out_Euclidean_Distatnce), 32'(v.exp));
      InSample = 1'b0;
      InTest   = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] prev;
      vec_t          clean;

`ifdef DTW_ABS_COST_EN
      vecs[0] = '{8'b00000000, 8'b00000000, 0,  6'd0,  "zeros"};
      vecs[1] = '{8'b11111111, 8'b00000000, 0,  6'd12, "3333_vs_0000"};
      vecs[2] = '{8'b00011011, 8'b00000110, 0,  6'd1,  "0123_vs_0012"};
      vecs[3] = '{8'b00011011, 8'b00011011, 0,  6'd0,  "identical"};
      vecs[4] = '{8'b11111111, 8'b00000000, 12, 6'd12, "restart_with_pulse"};
      vecs[5] = '{8'b11100100, 8'b00011011, 4,  6'd8,  "3210_vs_0123"};
`else
      vecs[0] = '{8'b00000000, 8'b00000000, 0,  6'd0,  "zeros"};
      vecs[1] = '{8'b11111111, 8'b00000000, 0,  6'd36, "3333_vs_0000"};
      vecs[2] = '{8'b00011011, 8'b00000110, 0,  6'd1,  "0123_vs_0012"};
      vecs[3] = '{8'b00011011, 8'b00011011, 0,  6'd0,  "identical"};
      vecs[4] = '{8'b11111111, 8'b00000000, 12, 6'd36, "restart_with_pulse"};
      vecs[5] = '{8'b11100100, 8'b00011011, 4,  6'd20, "3210_vs_0123"};
`endif

      rst      = 1'b1;
      InSample = 1'b0;
      InTest   = 1'b0;
      Start    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset valid", 32'(valid), 32'd0);
      chk("reset out", 32'(Out_Euclidean_Distatnce), 32'd0);

      // Idle with toggling data but no Start: nothing may happen
      for (int k = 0; k < 12; k++) begin
         InSample = k[0];
         InTest   = ~k[0];
         @(negedge clk);
      end
      chk("idle valid", 32'(valid), 32'd0);
      chk("idle out", 32'(Out_Euclidean_Distatnce), 32'd0);
      InSample = 1'b0;
      InTest   = 1'b0;

      prev = '0;
      for (int v = 0; v < 6; v++) begin
         run(vecs[v], prev);
         prev = vecs[v].exp;
      end

      // Reset in the middle of LOAD abandons the operation
      @(negedge clk);
      Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         InSample = 1'b1;
         InTest   = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid-load reset valid", 32'(valid), 32'd0);
      chk("mid-load reset out", 32'(Out_Euclidean_Distatnce), 32'd0);
      repeat (30) @(negedge clk);
      chk("post-reset idle valid", 32'(valid), 32'd0);
      chk("post-reset idle out", 32'(Out_Euclidean_Distatnce), 32'd0);
      InSample = 1'b0;
      InTest   = 1'b0;

      clean = vecs[2];
      clean.name = "clean_after_reset";
      run(clean, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
